// File: rtl/arm_pipe_pkg.sv
// -----------------------------------------------------------------------------
// arm_pipe_pkg
// Shared types and constants for the ARM 5-stage pipeline control logic.
//   REG_ADDR_W       : register-file address width
//   MEM_TIMEOUT_DEF  : default number of WAIT cycles before the memory FSM
//                      declares a timeout
//   mem_state_t      : memory-wait FSM state encoding
// -----------------------------------------------------------------------------
package arm_pipe_pkg;

    localparam int REG_ADDR_W      = 4;
    localparam int MEM_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the datapath and the pipeline hazard controller.
//   master : datapath side (drives stage info, receives freeze/flush)
//   slave  : controller side
// Stage info   : id_valid, id_src_1, id_src_2, id_two_src, exe_wb_en,
//                exe_mem_r_en, exe_dest, mem_wb_en, mem_dest, exe_b_taken,
//                mem_req, mem_ready
// Control out  : pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze,
//                mem_start, mem_timeout, stall_count
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if
    import arm_pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 16
);
    logic                   id_valid;
    logic [REG_ADDR_W-1:0]  id_src_1;
    logic [REG_ADDR_W-1:0]  id_src_2;
    logic                   id_two_src;
    logic                   exe_wb_en;
    logic                   exe_mem_r_en;
    logic [REG_ADDR_W-1:0]  exe_dest;
    logic                   mem_wb_en;
    logic [REG_ADDR_W-1:0]  mem_dest;
    logic                   exe_b_taken;
    logic                   mem_req;
    logic                   mem_ready;

    logic                   pc_freeze;
    logic                   if_freeze;
    logic                   if_flush;
    logic                   id_flush;
    logic                   pipe_freeze;
    logic                   mem_start;
    logic                   mem_timeout;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_src_1, id_src_2, id_two_src,
               exe_wb_en, exe_mem_r_en, exe_dest,
               mem_wb_en, mem_dest, exe_b_taken, mem_req, mem_ready,
        input  pc_freeze, if_freeze, if_flush, id_flush,
               pipe_freeze, mem_start, mem_timeout, stall_count
    );

    modport slave (
        input  id_valid, id_src_1, id_src_2, id_two_src,
               exe_wb_en, exe_mem_r_en, exe_dest,
               mem_wb_en, mem_dest, exe_b_taken, mem_req, mem_ready,
        output pc_freeze, if_freeze, if_flush, id_flush,
               pipe_freeze, mem_start, mem_timeout, stall_count
    );

endinterface

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational read-after-write hazard detection for the ID stage.
//   FWD_EN=1 : forwarding covers everything except a load in EXE, so only
//              an EXE load-use dependency stalls.
//   FWD_EN=0 : any pending write in EXE or MEM to a register read in ID stalls.
// Ports:
//   i_id_valid, i_id_src_1, i_id_src_2, i_id_two_src : ID-stage operands
//   i_exe_wb_en, i_exe_mem_r_en, i_exe_dest          : EXE-stage writer
//   i_mem_wb_en, i_mem_dest                          : MEM-stage writer
//   o_hz                                             : stall request
// -----------------------------------------------------------------------------
module hazard_detect
    import arm_pipe_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_src_1,
    input  logic [REG_ADDR_W-1:0] i_id_src_2,
    input  logic                  i_id_two_src,
    input  logic                  i_exe_wb_en,
    input  logic                  i_exe_mem_r_en,
    input  logic [REG_ADDR_W-1:0] i_exe_dest,
    input  logic                  i_mem_wb_en,
    input  logic [REG_ADDR_W-1:0] i_mem_dest,
    output logic                  o_hz
);

    logic w_exe_match, w_mem_match;
    logic w_exe_hit, w_mem_hit;

    // src_2 only counts when the instruction actually reads it
    assign w_exe_match = (i_id_src_1 == i_exe_dest) |
                         (i_id_two_src & (i_id_src_2 == i_exe_dest));
    assign w_mem_match = (i_id_src_1 == i_mem_dest) |
                         (i_id_two_src & (i_id_src_2 == i_mem_dest));

    assign w_exe_hit = i_exe_wb_en & w_exe_match;
    assign w_mem_hit = i_mem_wb_en & w_mem_match;

    assign o_hz = i_id_valid & (FWD_EN ? (w_exe_hit & i_exe_mem_r_en)
                                       : (w_exe_hit | w_mem_hit));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Sequencing controller for the IF/ID/EXE/MEM stage registers.
//   - PC/IF freeze and ID bubble on data hazards
//   - IF/ID flush on a taken branch resolved in EXE
//   - global pipeline freeze while an SRAM access is outstanding, with a
//     timeout that parks the FSM in a sticky error state until reset
//   - saturating count of cycles spent with the PC frozen
// Priority: memory freeze > branch flush > hazard stall.
// Ports:
//   clk   : pipeline clock
//   rst   : synchronous active-low reset; all outputs held at 0 while low
//   bus   : pipeline_hazard_ctrl_if.slave (stage info in, control out)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter bit FWD_EN      = 1'b1,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int STALL_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    pipeline_hazard_ctrl_if.slave   bus
);

    localparam int               CNT_W       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    mem_state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_wait_cnt, w_wait_cnt_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_hz;
    logic w_freeze_raw, w_start_raw, w_timeout_raw;
    logic w_pc_freeze;

    hazard_detect #(
        .FWD_EN (FWD_EN)
    ) u_hazard_detect (
        .i_id_valid     (bus.id_valid),
        .i_id_src_1     (bus.id_src_1),
        .i_id_src_2     (bus.id_src_2),
        .i_id_two_src   (bus.id_two_src),
        .i_exe_wb_en    (bus.exe_wb_en),
        .i_exe_mem_r_en (bus.exe_mem_r_en),
        .i_exe_dest     (bus.exe_dest),
        .i_mem_wb_en    (bus.mem_wb_en),
        .i_mem_dest     (bus.mem_dest),
        .o_hz           (w_hz)
    );

    // ---------------- memory-wait FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // ---------------- memory-wait FSM: next state ----------------
    // wait_cnt counts WAIT cycles already spent, starting at 1 on entry.
    // A ready on the final allowed cycle still completes the access.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            IDLE: begin
                // a stray mem_ready here is ignored, which also guarantees
                // a load/store spends at least two cycles in MEM
                if (bus.mem_req) begin
                    w_state_nxt    = WAIT;
                    w_wait_cnt_nxt = CNT_W'(1);
                end
            end
            WAIT: begin
                if (bus.mem_ready) begin
                    w_state_nxt    = IDLE;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == TIMEOUT_VAL) begin
                    w_state_nxt = ERR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            ERR:     w_state_nxt = ERR;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- memory-wait FSM: outputs ----------------
    always_comb begin
        w_freeze_raw  = 1'b0;
        w_start_raw   = 1'b0;
        w_timeout_raw = 1'b0;
        case (r_state)
            IDLE: begin
                w_freeze_raw = bus.mem_req;
                w_start_raw  = bus.mem_req;
            end
            WAIT: w_freeze_raw = ~bus.mem_ready;   // release on the ready edge
            ERR: begin
                w_freeze_raw  = 1'b1;
                w_timeout_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // A taken branch squashes the dependent instruction, so the hazard no
    // longer needs the PC held. During a freeze the EXE reg keeps the branch,
    // so its flush simply lands on the release cycle.
    assign w_pc_freeze = rst & (w_freeze_raw | (w_hz & ~bus.exe_b_taken));

    assign bus.pc_freeze   = w_pc_freeze;
    assign bus.if_freeze   = w_pc_freeze;
    assign bus.if_flush    = rst & ~w_freeze_raw & bus.exe_b_taken;
    assign bus.id_flush    = rst & ~w_freeze_raw & (bus.exe_b_taken | w_hz);
    assign bus.pipe_freeze = rst & w_freeze_raw;
    assign bus.mem_start   = rst & w_start_raw;
    assign bus.mem_timeout = rst & w_timeout_raw;
    assign bus.stall_count = rst ? r_stall_cnt : '0;

    // ---------------- saturating stall counter ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_pc_freeze && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Two controllers share one stimulus stream:
//   dut_a : FWD_EN=1, MEM_TIMEOUT=4,  STALL_CNT_W=16
//   dut_b : FWD_EN=0, MEM_TIMEOUT=15, STALL_CNT_W=4 (saturates quickly)
// Control vector order: {pc_freeze, if_freeze, if_flush, id_flush,
//                        pipe_freeze, mem_start, mem_timeout}
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
    import arm_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.STALL_CNT_W(16)) ifa ();
    pipeline_hazard_ctrl_if #(.STALL_CNT_W(4))  ifb ();

    assign ifb.id_valid     = ifa.id_valid;
    assign ifb.id_src_1     = ifa.id_src_1;
    assign ifb.id_src_2     = ifa.id_src_2;
    assign ifb.id_two_src   = ifa.id_two_src;
    assign ifb.exe_wb_en    = ifa.exe_wb_en;
    assign ifb.exe_mem_r_en = ifa.exe_mem_r_en;
    assign ifb.exe_dest     = ifa.exe_dest;
    assign ifb.mem_wb_en    = ifa.mem_wb_en;
    assign ifb.mem_dest     = ifa.mem_dest;
    assign ifb.exe_b_taken  = ifa.exe_b_taken;
    assign ifb.mem_req      = ifa.mem_req;
    assign ifb.mem_ready    = ifa.mem_ready;

    pipeline_hazard_ctrl #(
        .FWD_EN(1'b1), .MEM_TIMEOUT(4), .STALL_CNT_W(16)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    pipeline_hazard_ctrl #(
        .FWD_EN(1'b0), .MEM_TIMEOUT(15), .STALL_CNT_W(4)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    localparam logic [6:0] Z  = 7'b0000000;  // quiet
    localparam logic [6:0] HZ = 7'b1101000;  // hazard stall + bubble
    localparam logic [6:0] MS = 7'b1100110;  // mem start in IDLE
    localparam logic [6:0] MW = 7'b1100100;  // waiting on SRAM
    localparam logic [6:0] BR = 7'b0011000;  // branch flush
    localparam logic [6:0] ER = 7'b1100101;  // timeout error

    typedef struct {
        string      tag;
        logic [6:0] a;
        logic [6:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [6:0] obs_a();
        return {ifa.pc_freeze, ifa.if_freeze, ifa.if_flush, ifa.id_flush,
                ifa.pipe_freeze, ifa.mem_start, ifa.mem_timeout};
    endfunction

    function automatic logic [6:0] obs_b();
        return {ifb.pc_freeze, ifb.if_freeze, ifb.if_flush, ifb.id_flush,
                ifb.pipe_freeze, ifb.mem_start, ifb.mem_timeout};
    endfunction

    task automatic chk7(input string tag, input logic [6:0] o, input logic [6:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, o, e);
    endtask

    task automatic chk_cnt(input string tag, input int o, input int e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    endtask

    // one pipeline cycle: queue the expectation, compare mid-cycle, advance
    task automatic step(input string tag, input logic [6:0] ea, input logic [6:0] eb);
        exp_t e;
        e.tag = tag;
        e.a   = ea;
        e.b   = eb;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_chk++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk7({e.tag, "/A"}, obs_a(), e.a);
            chk7({e.tag, "/B"}, obs_b(), e.b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cnts(input string tag, input int ea, input int eb);
        chk_cnt({tag, "/A"}, int'(ifa.stall_count), ea);
        chk_cnt({tag, "/B"}, int'(ifb.stall_count), eb);
    endtask

    task automatic clr();
        ifa.id_valid     = 1'b0;
        ifa.id_src_1     = '0;
        ifa.id_src_2     = '0;
        ifa.id_two_src   = 1'b0;
        ifa.exe_wb_en    = 1'b0;
        ifa.exe_mem_r_en = 1'b0;
        ifa.exe_dest     = '0;
        ifa.mem_wb_en    = 1'b0;
        ifa.mem_dest     = '0;
        ifa.exe_b_taken  = 1'b0;
        ifa.mem_req      = 1'b0;
        ifa.mem_ready    = 1'b0;
    endtask

    // EXE load to r3, ID reads r3 through src_1
    task automatic set_ld_use();
        ifa.id_valid     = 1'b1;
        ifa.exe_wb_en    = 1'b1;
        ifa.exe_mem_r_en = 1'b1;
        ifa.exe_dest     = 4'd3;
        ifa.id_src_1     = 4'd3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        // reset forces outputs low even with a hazard and a mem request
        clr();
        rst = 1'b0;
        set_ld_use();
        ifa.mem_req = 1'b1;
        @(posedge clk);
        #1;
        step("rst_force0", Z, Z);
        step("rst_force1", Z, Z);
        cnts("rst_cnt", 0, 0);

        // load-use hazard
        rst = 1'b1;
        clr();
        set_ld_use();
        cnts("pre_stall", 0, 0);
        step("ld_use", HZ, HZ);
        cnts("ld_use_cnt", 1, 1);

        // plain ALU producer: forwarding covers it, no-forwarding stalls
        ifa.exe_mem_r_en = 1'b0;
        step("alu_raw", Z, HZ);

        // MEM-stage writer matched through src_2
        ifa.exe_wb_en  = 1'b0;
        ifa.exe_dest   = 4'd0;
        ifa.id_src_1   = 4'd0;
        ifa.mem_wb_en  = 1'b1;
        ifa.mem_dest   = 4'd5;
        ifa.id_two_src = 1'b1;
        ifa.id_src_2   = 4'd5;
        step("mem_raw_m2", Z, HZ);
        ifa.id_two_src = 1'b0;
        step("m2_unused", Z, Z);
        ifa.id_two_src = 1'b1;
        ifa.id_valid   = 1'b0;
        step("id_invalid", Z, Z);
        cnts("raw_cnt", 1, 3);

        // SRAM access, ready on 3rd WAIT cycle
        clr();
        ifa.mem_req = 1'b1;
        step("mem_idle", MS, MS);
        step("mem_wait1", MW, MW);
        step("mem_wait2", MW, MW);
        ifa.mem_ready = 1'b1;
        step("mem_ready", Z, Z);
        clr();
        step("mem_back", Z, Z);
        ifa.mem_ready = 1'b1;
        step("rdy_in_idle", Z, Z);
        ifa.mem_ready = 1'b0;
        step("still_idle", Z, Z);
        cnts("mem_cnt", 4, 6);

        // branch beats hazard
        set_ld_use();
        ifa.exe_b_taken = 1'b1;
        step("br_hz", BR, BR);
        clr();

        // branch during freeze: flush deferred to release cycle
        ifa.mem_req = 1'b1;
        step("br_mem_idle", MS, MS);
        ifa.exe_b_taken = 1'b1;
        step("br_frozen", MW, MW);
        ifa.mem_ready = 1'b1;
        step("br_release", BR, BR);
        clr();
        step("br_done", Z, Z);
        cnts("br_cnt", 6, 8);

        // timeout: A (limit 4) errors, B (limit 15) keeps waiting
        ifa.mem_req = 1'b1;
        step("to_idle", MS, MS);
        for (int i = 0; i < 4; i++) step("to_wait", MW, MW);
        step("to_err", ER, MW);
        ifa.mem_req     = 1'b0;
        ifa.mem_ready   = 1'b1;
        ifa.exe_b_taken = 1'b1;
        step("err_hold", ER, BR);
        clr();
        step("err_sticky", ER, Z);
        cnts("to_cnt", 14, 14);
        rst = 1'b0;
        step("rst_pulse", Z, Z);
        rst = 1'b1;
        step("err_cleared", Z, Z);
        cnts("rst_cnt2", 0, 0);

        // stall counter saturation (B is 4 bits wide)
        set_ld_use();
        for (int i = 0; i < 15; i++) step("sat_run", HZ, HZ);
        cnts("cnt15", 15, 15);
        for (int i = 0; i < 5; i++) step("sat_hold", HZ, HZ);
        cnts("cnt_sat", 20, 15);

        // reset in the middle of WAIT
        clr();
        ifa.mem_req = 1'b1;
        step("rw_idle", MS, MS);
        step("rw_wait", MW, MW);
        rst = 1'b0;
        step("rw_rst", Z, Z);
        rst = 1'b1;
        ifa.mem_req = 1'b0;
        step("rw_after", Z, Z);
        cnts("rw_cnt", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the ARM 5-stage pipeline registers (IF/ID/EXE/MEM stage regs).
- Generates PC/IF freeze, IF and ID flush (bubble insertion), and a global freeze for multi-cycle SRAM accesses.
- Contains a memory-wait FSM with timeout, plus a saturating stall counter for performance debug.
- Sits beside the datapath, taking register-address and control bits from ID, EXE and MEM stages.

Parameters:
FWD_EN, 1, 1 = forwarding unit present, so only EXE load-use stalls; 0 = stall on any EXE/MEM RAW match
MEM_TIMEOUT, 15, max WAIT cycles without mem_ready before the error state (>=1)
STALL_CNT_W, 16, width of stall_count

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_src_1  in  4  Rn address in ID
id_src_2  in  4  Rm/Rd-store address in ID
id_two_src  in  1  id_src_2 is read by the ID instruction
exe_wb_en  in  1  EXE instruction writes back
exe_mem_r_en  in  1  EXE instruction is a load
exe_dest  in  4  EXE destination register
mem_wb_en  in  1  MEM instruction writes back
mem_dest  in  4  MEM destination register
exe_b_taken  in  1  branch resolved taken in EXE
mem_req  in  1  MEM-stage instruction is a load/store
mem_ready  in  1  SRAM access complete (single-cycle pulse)
pc_freeze  out  1  hold PC
if_freeze  out  1  hold IF stage reg
if_flush  out  1  clear IF stage reg
id_flush  out  1  clear ID stage reg (bubble)
pipe_freeze  out  1  hold ID/EXE/MEM stage regs
mem_start  out  1  SRAM access start pulse
mem_timeout  out  1  sticky error
stall_count  out  STALL_CNT_W  cycles with pc_freeze=1, saturating

Behaviour:
- Reset (rst=0 at posedge): FSM enters IDLE; wait_cnt, stall_count and mem_timeout are cleared. While rst=0 all outputs are forced to 0.
- Hazard (combinational):
  - m1 = id_src_1 match; m2 = id_two_src & id_src_2 match.
  - FWD_EN=1: hz = id_valid & exe_wb_en & exe_mem_r_en & (exe_dest matches m1|m2).
  - FWD_EN=0: hz = id_valid & ((exe_wb_en & EXE match) | (mem_wb_en & MEM match)).
- Memory FSM states: IDLE, WAIT, ERR.
  - IDLE: mem_req=1 -> mem_start=1 (Mealy), pipe_freeze=1, next state WAIT, wait_cnt=1. mem_ready while in IDLE is ignored.
  - WAIT: pipe_freeze = ~mem_ready.
    - mem_ready=1 -> IDLE; the pipeline advances at that edge.
    - Otherwise, if wait_cnt==MEM_TIMEOUT -> ERR; else wait_cnt+1.
    - mem_ready on the timeout cycle wins (goes to IDLE).
  - ERR: pipe_freeze=1, mem_timeout=1, held until reset.
- Minimum load/store occupancy of MEM stage: 2 cycles.
- Outputs and priority (pipe_freeze > branch > hazard):
  - pc_freeze = if_freeze = pipe_freeze | (hz & ~exe_b_taken)
  - if_flush = ~pipe_freeze & exe_b_taken
  - id_flush = ~pipe_freeze & (exe_b_taken | hz)
- Branch during freeze: no flush is issued. The EXE reg is held, so exe_b_taken stays asserted and the flush is issued on the release cycle.
- Branch and hazard in the same cycle: branch wins; the dependent instruction is squashed and the PC is not frozen.
- stall_count: +1 on each cycle with pc_freeze=1; saturates at 2^STALL_CNT_W-1.

Decomposition:
- Package arm_pipe_pkg:
  - mem_state_t enum {IDLE, WAIT, ERR}
  - REG_ADDR_W=4
  - default MEM_TIMEOUT
- Sub-module hazard_detect: purely combinational hz generation, parameterised by FWD_EN, reused by the forwarding unit bench.

Test Plan:
1. FWD_EN=1; exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src_1=3, id_valid=1 -> pc_freeze=if_freeze=id_flush=1, if_flush=0, stall_count 0->1.
2. Same as 1 with exe_mem_r_en=0 -> no stall. With FWD_EN=0: mem_wb_en=1, mem_dest=5, id_two_src=1, id_src_2=5 -> stall.
3. mem_req=1 in IDLE, mem_ready on 3rd WAIT cycle -> mem_start pulses 1 cycle; pipe_freeze=1 for 3 cycles (IDLE cycle + 2 WAIT cycles), 0 on the ready cycle; FSM returns to IDLE.
4. MEM_TIMEOUT=4, mem_req=1, no mem_ready -> ERR after 4 WAIT cycles; mem_timeout=1 and pipe_freeze held. Asserting rst=0 for 1 cycle clears both.
5. exe_b_taken=1 with a hazard present -> if_flush=id_flush=1, pc_freeze=0. exe_b_taken=1 during WAIT -> flushes held off until the mem_ready cycle.
6. Drive pc_freeze continuously for 2^16+5 cycles -> stall_count stays at 0xFFFF; rst=0 mid-WAIT -> FSM IDLE, outputs 0.
